// File: rtl/unidad_resolucion_salto.sv
// rtl/unidad_resolucion_salto.sv - EX-stage branch resolver with registered redirect and multi-cycle flush
// Optional UNIDAD_SALTO_PERF_EN adds the cnt_saltos/cnt_fallos performance counters.
module unidad_resolucion_salto #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      funct3,
    input  logic            igual,
    input  logic            menor,
    input  logic            menor_u,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_taken,
    output logic            taken,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            illegal
`ifdef UNIDAD_SALTO_PERF_EN
    ,
    output logic [31:0]     cnt_saltos,
    output logic [31:0]     cnt_fallos
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] fcnt_q, fcnt_d;

    logic            transfer;
    logic            dir;
    logic            es_ilegal;
    logic            fallo;
    logic [XLEN-1:0] destino;

    assign transfer = br_valid & br_ready;

    always_comb begin
        dir       = 1'b0;
        es_ilegal = 1'b0;
        case (funct3)
            3'b000:  dir = igual;
            3'b001:  dir = ~igual;
            3'b100:  dir = menor;
            3'b101:  dir = ~menor;
            3'b110:  dir = menor_u;
            3'b111:  dir = ~menor_u;
            default: es_ilegal = 1'b1;
        endcase
    end

    // Illegal encodings resolve not-taken and can never trigger a redirect.
    assign fallo   = ~es_ilegal & (dir != pred_taken);
    assign destino = dir ? (pc + imm) : (pc + XLEN'(4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        br_ready = 1'b1;
        flush    = 1'b0;
        case (state_q)
            IDLE: begin
                if (transfer && fallo) begin
                    state_d = FLUSH;
                    fcnt_d  = 4'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                br_ready = 1'b0;
                flush    = 1'b1;
                if (fcnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = 4'd0;
            end
        endcase
    end

    // taken/redirect_pc hold between transfers; mispredict/illegal are pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken       <= 1'b0;
            mispredict  <= 1'b0;
            illegal     <= 1'b0;
            redirect_pc <= '0;
        end else begin
            mispredict <= 1'b0;
            illegal    <= 1'b0;
            if (transfer) begin
                taken       <= dir;
                mispredict  <= fallo;
                illegal     <= es_ilegal;
                redirect_pc <= destino;
            end
        end
    end

`ifdef UNIDAD_SALTO_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_saltos <= 32'd0;
            cnt_fallos <= 32'd0;
        end else if (transfer) begin
            if (!es_ilegal) begin
                cnt_saltos <= cnt_saltos + 32'd1;
            end
            if (fallo) begin
                cnt_fallos <= cnt_fallos + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_unidad_resolucion_salto.sv
// tb/tb_unidad_resolucion_salto.sv - directed self-checking bench for unidad_resolucion_salto
module tb_unidad_resolucion_salto;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  funct3;
    logic        igual;
    logic        menor;
    logic        menor_u;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred_taken;
    logic        taken;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        illegal;
`ifdef UNIDAD_SALTO_PERF_EN
    logic [31:0] cnt_saltos;
    logic [31:0] cnt_fallos;
`endif

    int checks = 0;
    int errors = 0;

    unidad_resolucion_salto #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .br_valid    (br_valid),
        .br_ready    (br_ready),
        .funct3      (funct3),
        .igual       (igual),
        .menor       (menor),
        .menor_u     (menor_u),
        .pc          (pc),
        .imm         (imm),
        .pred_taken  (pred_taken),
        .taken       (taken),
        .mispredict  (mispredict),
        .redirect_pc (redirect_pc),
        .flush       (flush),
        .illegal     (illegal)
`ifdef UNIDAD_SALTO_PERF_EN
        ,
        .cnt_saltos  (cnt_saltos),
        .cnt_fallos  (cnt_fallos)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f3, input logic ig, input logic mn, input logic mu,
                         input logic [31:0] p, input logic [31:0] im, input logic pt);
        br_valid   = 1'b1;
        funct3     = f3;
        igual      = ig;
        menor      = mn;
        menor_u    = mu;
        pc         = p;
        imm        = im;
        pred_taken = pt;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        br_valid = 1'b0;
        repeat (2) tick;
        chk("rst_taken", 32'(taken), 32'd0);
        chk("rst_mispredict", 32'(mispredict), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_redirect", redirect_pc, 32'h0);
        chk("rst_br_ready", 32'(br_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // T1 BEQ taken, predicted not taken
        drive(3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20, 1'b0);
        tick;
        br_valid = 1'b0;
        chk("t1_taken", 32'(taken), 32'd1);
        chk("t1_mispredict", 32'(mispredict), 32'd1);
        chk("t1_redirect", redirect_pc, 32'h120);
        chk("t1_flush_c1", 32'(flush), 32'd1);
        chk("t1_ready_c1", 32'(br_ready), 32'd0);
        tick;
        chk("t1_mispredict_pulse", 32'(mispredict), 32'd0);
        chk("t1_flush_c2", 32'(flush), 32'd1);
        chk("t1_ready_c2", 32'(br_ready), 32'd0);
        tick;
        chk("t1_flush_end", 32'(flush), 32'd0);
        chk("t1_ready_end", 32'(br_ready), 32'd1);

        // T2 BNE with equal operands, correctly predicted not taken
        drive(3'b001, 1'b1, 1'b0, 1'b0, 32'h200, 32'h40, 1'b0);
        tick;
        br_valid = 1'b0;
        chk("t2_taken", 32'(taken), 32'd0);
        chk("t2_mispredict", 32'(mispredict), 32'd0);
        chk("t2_flush", 32'(flush), 32'd0);
        chk("t2_ready", 32'(br_ready), 32'd1);
        chk("t2_redirect", redirect_pc, 32'h204);

        // BGE with negative offset, correctly predicted taken
        drive(3'b101, 1'b0, 1'b0, 1'b1, 32'h1000, 32'hFFFF_FFF0, 1'b1);
        tick;
        chk("bge_taken", 32'(taken), 32'd1);
        chk("bge_mispredict", 32'(mispredict), 32'd0);
        chk("bge_redirect", redirect_pc, 32'h0000_0FF0);

        // T3 BLT then BLTU back-to-back on A=0xFFFFFFFF, B=1
        drive(3'b100, 1'b0, 1'b1, 1'b0, 32'h300, 32'h10, 1'b1);
        tick;
        chk("t3_blt_taken", 32'(taken), 32'd1);
        chk("t3_blt_mispredict", 32'(mispredict), 32'd0);
        chk("t3_blt_redirect", redirect_pc, 32'h310);
        chk("t3_blt_ready", 32'(br_ready), 32'd1);
        drive(3'b110, 1'b0, 1'b1, 1'b0, 32'h300, 32'h10, 1'b1);
        tick;
        chk("t3_bltu_taken", 32'(taken), 32'd0);
        chk("t3_bltu_mispredict", 32'(mispredict), 32'd1);
        chk("t3_bltu_redirect", redirect_pc, 32'h304);
        chk("t3_bltu_flush", 32'(flush), 32'd1);

        // T5 taken BEQ offered while flushing must be ignored
        drive(3'b000, 1'b1, 1'b0, 1'b0, 32'h500, 32'h8, 1'b0);
        tick;
        chk("t5_taken_c1", 32'(taken), 32'd0);
        chk("t5_redirect_c1", redirect_pc, 32'h304);
        chk("t5_mispredict_c1", 32'(mispredict), 32'd0);
        chk("t5_flush_c1", 32'(flush), 32'd1);
        tick;
        br_valid = 1'b0;
        chk("t5_taken_c2", 32'(taken), 32'd0);
        chk("t5_redirect_c2", redirect_pc, 32'h304);
        chk("t5_mispredict_c2", 32'(mispredict), 32'd0);
        chk("t5_flush_end", 32'(flush), 32'd0);
        chk("t5_ready_end", 32'(br_ready), 32'd1);

        // T4 PC wrap-around on a mispredicted not-taken BEQ
        drive(3'b000, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h100, 1'b1);
        tick;
        br_valid = 1'b0;
        chk("t4_taken", 32'(taken), 32'd0);
        chk("t4_mispredict", 32'(mispredict), 32'd1);
        chk("t4_redirect", redirect_pc, 32'h0000_0000);
        chk("t4_flush", 32'(flush), 32'd1);

        // T6 asynchronous reset one cycle into the flush
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_flush_async", 32'(flush), 32'd0);
        chk("t6_ready_async", 32'(br_ready), 32'd1);
        chk("t6_taken_async", 32'(taken), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ready_release", 32'(br_ready), 32'd1);
        drive(3'b011, 1'b1, 1'b1, 1'b1, 32'h400, 32'h80, 1'b1);
        tick;
        br_valid = 1'b0;
        chk("t6_illegal", 32'(illegal), 32'd1);
        chk("t6_ill_taken", 32'(taken), 32'd0);
        chk("t6_ill_mispredict", 32'(mispredict), 32'd0);
        chk("t6_ill_flush", 32'(flush), 32'd0);
        chk("t6_ill_redirect", redirect_pc, 32'h404);
        tick;
        chk("t6_illegal_pulse", 32'(illegal), 32'd0);
        chk("t6_ill_ready", 32'(br_ready), 32'd1);

        // funct3=010 is also illegal and must not flush
        drive(3'b010, 1'b0, 1'b0, 1'b0, 32'h600, 32'h4, 1'b1);
        tick;
        br_valid = 1'b0;
        chk("ill010_illegal", 32'(illegal), 32'd1);
        chk("ill010_mispredict", 32'(mispredict), 32'd0);
        chk("ill010_flush", 32'(flush), 32'd0);

        // BGEU with menor_u=1 is not taken; predicted not taken
        drive(3'b111, 1'b0, 1'b0, 1'b1, 32'h700, 32'h20, 1'b0);
        tick;
        br_valid = 1'b0;
        chk("bgeu_taken", 32'(taken), 32'd0);
        chk("bgeu_mispredict", 32'(mispredict), 32'd0);
        chk("bgeu_illegal", 32'(illegal), 32'd0);
        chk("bgeu_redirect", redirect_pc, 32'h704);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
